uart_report_tx: RTL
===================

Name: uart_report_tx

Overview:
- Transmit side of the 9600-baud 8N1 UART string link; counterpart of the command-string receiver that drives the fan and humidity LEDs.
- On a send strobe, captures one DHT11 temperature/humidity sample and formats it as ASCII "T:tt,H:hh\n".
- Serialises the string LSB-first on tx, back-to-back, then signals completion.
- Sits between the DHT11 reader and the board UART TX pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, (CLK_FREQ + BAUD/2)/BAUD = 10417, clocks per bit; derived, never overridden.

Ports:
- clk_100Mhz  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- temp  input  8  temperature, unsigned binary, degrees C.
- hum  input  8  relative humidity, unsigned binary, percent.
- send  input  1  request strobe; sampled every cycle.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high from the cycle after an accepted send until done.
- done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, done=0, all counters 0, FSM IDLE. Reset mid-frame forces tx=1 immediately and abandons the string.
- Accept: send=1 while busy=0 captures temp/hum in the same edge; busy=1 next cycle. send while busy=1 is ignored, with no queueing.
- Value rule: each captured value greater than 99 saturates to 99. Emit two decimal digits with a leading zero ('0'+v/10, '0'+v%10). Digits are computed at capture as registered values, not per byte.
- String: 'T' ':' T10 T1 ',' 'H' ':' H10 H1 '\n', i.e. 10 bytes, index 0..9.
- Top FSM:
  - IDLE -> LOAD on accept.
  - LOAD selects byte[idx] and pulses the byte-TX start -> WAIT.
  - WAIT -> LOAD on byte done if idx<last (idx+1); otherwise -> FIN.
  - FIN pulses done, drops busy -> IDLE.
- Byte frame: start bit 0 for CLKS_PER_BIT cycles, then 8 data bits LSB first, each CLKS_PER_BIT cycles, then stop bit 1 for CLKS_PER_BIT cycles.
- Latency:
  - The start bit of byte 0 begins 2 cycles after the accept edge.
  - Consecutive bytes have at most 1 cycle of extra idle-high between stop and next start.
- Bit counter: 0..CLKS_PER_BIT-1, wraps at terminal count; bit index 0..7.
- Completion: done pulses exactly once per accepted string, in the same cycle busy falls. send in that done cycle is ignored; send the cycle after is accepted.

Optional Feature:
- Macro: UART_REPORT_CHECKSUM_EN.
- Defined: insert '*' plus two uppercase hex digits of the XOR of bytes 0..8 before '\n' → 13 bytes. Example: "T:25,H:60*31\n".
- Undefined: 10-byte string; no checksum logic synthesised.
- Ports and timing rules are identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants ('T','H',':',',','*','\n','0','A').
  - CLKS_PER_BIT derivation function.
  - Message length constants MSG_LEN=10 and MSG_LEN_CK=13.
  - Shared with the receiver.
- One sub-module, uart_tx_byte:
  - Inputs: start, data[7:0]. Outputs: tx, busy, done.
  - Contains the baud counter and the start/data/stop shift.
- Top level holds capture, BCD conversion, byte mux and the sequencing FSM.

Test Plan:
- temp=25, hum=60, send pulse:
  - Decoded bytes 54 3A 32 35 2C 48 3A 36 30 0A.
  - Each bit measured at 10417 clocks ±1.
  - done exactly once; busy low afterwards.
- temp=7, hum=0 → "T:07,H:00\n" (leading zeros). temp=150, hum=255 → "T:99,H:99\n".
- send held high for 3 cycles, then send pulsed again mid-string → exactly one string transmitted; the second request is ignored.
- rst_n low during byte 3 data bits → tx=1 asynchronously, busy=0. A new send after release transmits a complete, correct string.
- Back-to-back: send in the cycle after done → the new string starts 2 cycles later; idle gap between byte 9 stop and the new start is ≤3 cycles.
- With UART_REPORT_CHECKSUM_EN, temp=25, hum=60 → bytes 54 3A 32 35 2C 48 3A 36 30 2A 33 31 0A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, baud divisor derivation and
// message lengths, used by both the report transmitter and the command receiver.
package uart_pkg;

  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_H     = 8'h48;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_NL    = 8'h0A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

  localparam int unsigned MSG_LEN    = 10;
  localparam int unsigned MSG_LEN_CK = 13;

  // Rounded to the nearest integer so the bit period error stays below half a clock.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return ASC_0 + {4'h0, nib};
    else             return ASC_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each
// CLKS_PER_BIT clocks. tx is registered, so the line lags the state by one clock.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;
  logic             line;

  assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign busy = (state != B_IDLE);
  // Done fires in the last internal stop cycle so the next byte can start
  // with only one extra idle clock on the (delayed) line.
  assign done = (state == B_STOP) && tick;

  always_comb begin
    line = 1'b1;
    case (state)
      B_START: line = 1'b0;
      B_DATA:  line = shreg[0];
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= B_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= line;
      if (state == B_IDLE) begin
        cnt <= '0;
        if (start) begin
          shreg   <= data;
          bit_idx <= '0;
          state   <= B_START;
        end
      end else begin
        cnt <= tick ? '0 : cnt + CNT_W'(1);
        if (tick) begin
          case (state)
            B_START: state <= B_DATA;
            B_DATA: begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= B_STOP;
            end
            default: state <= B_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/uart_report_tx.sv
// Formats one temperature/humidity sample as "T:tt,H:hh\n" and sends it 8N1.
// Define UART_REPORT_CHECKSUM_EN to append "*XX" (hex XOR of bytes 0..8) before '\n'.
module uart_report_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  input  logic [7:0] temp,
  input  logic [7:0] hum,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
`ifdef UART_REPORT_CHECKSUM_EN
  localparam int unsigned LAST_IDX = MSG_LEN_CK - 1;
`else
  localparam int unsigned LAST_IDX = MSG_LEN - 1;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] t_tens, t_ones, h_tens, h_ones;
  logic [6:0] temp_sat, hum_sat;
  logic [7:0] cur_byte;
  logic       byte_start, byte_busy, byte_done;

  assign temp_sat = (temp > 8'd99) ? 7'd99 : temp[6:0];
  assign hum_sat  = (hum  > 8'd99) ? 7'd99 : hum[6:0];

  assign byte_start = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_WAIT) || byte_busy;
  assign done       = (state == S_FIN);

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      t_tens <= '0;
      t_ones <= '0;
      h_tens <= '0;
      h_ones <= '0;
    end else begin
      case (state)
        S_IDLE: if (send) begin
          t_tens <= 4'(temp_sat / 7'd10);
          t_ones <= 4'(temp_sat % 7'd10);
          h_tens <= 4'(hum_sat / 7'd10);
          h_ones <= 4'(hum_sat % 7'd10);
          idx    <= '0;
          state  <= S_LOAD;
        end
        S_LOAD: state <= S_WAIT;
        S_WAIT: if (byte_done) begin
          if (idx < 4'(LAST_IDX)) begin
            idx   <= idx + 4'd1;
            state <= S_LOAD;
          end else begin
            state <= S_FIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_REPORT_CHECKSUM_EN
  logic [7:0] cksum;
  assign cksum = ASC_T ^ ASC_COLON ^ {4'h3, t_tens} ^ {4'h3, t_ones} ^ ASC_COMMA
               ^ ASC_H ^ ASC_COLON ^ {4'h3, h_tens} ^ {4'h3, h_ones};
`endif

  always_comb begin
    cur_byte = ASC_NL;
    case (idx)
      4'd0: cur_byte = ASC_T;
      4'd1: cur_byte = ASC_COLON;
      4'd2: cur_byte = {4'h3, t_tens};
      4'd3: cur_byte = {4'h3, t_ones};
      4'd4: cur_byte = ASC_COMMA;
      4'd5: cur_byte = ASC_H;
      4'd6: cur_byte = ASC_COLON;
      4'd7: cur_byte = {4'h3, h_tens};
      4'd8: cur_byte = {4'h3, h_ones};
`ifdef UART_REPORT_CHECKSUM_EN
      4'd9:  cur_byte = ASC_STAR;
      4'd10: cur_byte = hex_char(cksum[7:4]);
      4'd11: cur_byte = hex_char(cksum[3:0]);
`endif
      default: cur_byte = ASC_NL;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk_100Mhz),
    .rst_n(rst_n),
    .start(byte_start),
    .data (cur_byte),
    .tx   (tx),
    .busy (byte_busy),
    .done (byte_done)
  );

endmodule
